// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared types and constants for the instruction-fetch front end.
//   fetch_state_t  : fetch FSM states (BOOT, REQ, HOLD, DRAIN)
//   fetch_word_t   : {pc, instr} pair carried through the skid register
//   NOP_INSTR      : instruction word presented while nothing valid is fetched
//   DEFAULT_RESET_PC : default first fetch address after reset
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_reg.sv
// fetch_skid_reg: one-entry {pc, instr} holding register.
// Parks a fetched word that arrived while the IF/ID boundary was stalled.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   load_i   in   capture word_i
//   clear_i  in   drop the parked word (wins over load_i)
//   word_i   in   {pc, instr} to park
//   word_o   out  parked {pc, instr}
module fetch_skid_reg
  import pc_fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        clear_i,
  input  fetch_word_t word_i,
  output fetch_word_t word_o
);

  fetch_word_t word_q;
  fetch_word_t word_d;

  // Next-state selection for the parked word.
  always_comb begin
    word_d = word_q;
    if (clear_i) begin
      word_d = '{pc: 32'h0000_0000, instr: 32'h0000_0000};
    end else if (load_i) begin
      word_d = word_i;
    end else begin
      word_d = word_q;
    end
  end

  // Parked-word register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '{pc: 32'h0000_0000, instr: 32'h0000_0000};
    end else begin
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch front end.
// Owns the fetch PC, drives a request/acknowledge instruction-memory port
// and registers fetched words into the IF/ID boundary. Handles stalls (the
// acked word is parked in a skid register) and flushes (a request already
// issued is never withdrawn; its response is drained and discarded).
// Ports:
//   CLK, CPU_RST_N      clock, asynchronous active-low reset
//   PC_In               next PC from the next-PC generator (or redirect target)
//   FlushF, StallF      redirect taken / IF/ID cannot accept
//   PCF                 current fetch address
//   ImemReq, ImemAddr   memory request valid / address
//   ImemAck, ImemRdata  memory response handshake / instruction word
//   InstrF, PcOutF      registered instruction and its PC
//   InstrValidF         InstrF/PcOutF valid
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = pc_fetch_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = pc_fetch_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        CPU_RST_N,
  input  logic [31:0] PC_In,
  input  logic        FlushF,
  input  logic        StallF,
  output logic [31:0] PCF,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrF,
  output logic [31:0] PcOutF,
  output logic        InstrValidF
);

  import pc_fetch_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcout_q, pcout_d;
  logic         valid_q, valid_d;
  logic         req_q, req_d;

  logic         skid_load_s;
  logic         skid_clear_s;
  logic [31:0]  drain_tgt_s;
  fetch_word_t  skid_in_s;
  fetch_word_t  skid_out_s;

  assign skid_in_s = '{pc: pcf_q, instr: ImemRdata};

  fetch_skid_reg u_skid (
    .clk_i   (CLK),
    .rst_ni  (CPU_RST_N),
    .load_i  (skid_load_s),
    .clear_i (skid_clear_s),
    .word_i  (skid_in_s),
    .word_o  (skid_out_s)
  );

  // Fetch FSM next-state and datapath next-values.
  always_comb begin
    state_d      = state_q;
    pcf_d        = pcf_q;
    target_d     = target_q;
    instr_d      = instr_q;
    pcout_d      = pcout_q;
    valid_d      = valid_q;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    // A redirect arriving in DRAIN replaces the pending target: last one wins.
    drain_tgt_s  = FlushF ? PC_In : target_q;

    case (state_q)
      BOOT: begin
        state_d = REQ;
      end

      REQ: begin
        if (FlushF) begin
          valid_d = 1'b0;
          if (ImemAck) begin
            // Response of the wrong-path fetch is dropped; fetch the target next.
            pcf_d = PC_In;
          end else begin
            // Request must stay up until acked, so remember where to go.
            target_d = PC_In;
            state_d  = DRAIN;
          end
        end else if (ImemAck) begin
          if (StallF) begin
            skid_load_s = 1'b1;
            state_d     = HOLD;
          end else begin
            instr_d = ImemRdata;
            pcout_d = pcf_q;
            valid_d = 1'b1;
            pcf_d   = PC_In;
          end
        end else if (!StallF) begin
          // Decode consumed the word on display and nothing new arrived.
          valid_d = 1'b0;
        end else begin
          valid_d = valid_q;
        end
      end

      HOLD: begin
        if (FlushF) begin
          skid_clear_s = 1'b1;
          pcf_d        = PC_In;
          valid_d      = 1'b0;
          state_d      = REQ;
        end else if (!StallF) begin
          skid_clear_s = 1'b1;
          instr_d      = skid_out_s.instr;
          pcout_d      = skid_out_s.pc;
          valid_d      = 1'b1;
          pcf_d        = PC_In;
          state_d      = REQ;
        end else begin
          state_d = HOLD;
        end
      end

      DRAIN: begin
        target_d = drain_tgt_s;
        if (ImemAck) begin
          pcf_d   = drain_tgt_s;
          state_d = REQ;
        end else begin
          state_d = DRAIN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase

    req_d = (state_d == REQ) || (state_d == DRAIN);
  end

  // State, PC and IF/ID output registers.
  always_ff @(posedge CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_q  <= BOOT;
      pcf_q    <= RESET_PC;
      target_q <= 32'h0000_0000;
      instr_q  <= NOP_INSTR;
      pcout_q  <= 32'h0000_0000;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcf_q    <= pcf_d;
      target_q <= target_d;
      instr_q  <= instr_d;
      pcout_q  <= pcout_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
    end
  end

  assign PCF         = pcf_q;
  assign ImemAddr    = pcf_q;
  assign ImemReq     = req_q;
  assign InstrF      = instr_q;
  assign PcOutF      = pcout_q;
  assign InstrValidF = valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit.
// A transaction-level model (outstanding request / parked word / killed
// request) predicts every output each cycle; literal checks pin key points.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        CPU_RST_N = 1'b0;
  logic [31:0] PC_In, PCF, ImemAddr, ImemRdata, InstrF, PcOutF;
  logic        FlushF, StallF, ImemReq, ImemAck, InstrValidF;

  logic        ack_v, stall_v, flush_v, ovr_v;
  logic [31:0] ovr_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  // Memory answers with an address-tagged word; generator adds 4 unless redirected.
  assign ImemRdata = mem_word(ImemAddr);
  assign ImemAck   = ack_v;
  assign StallF    = stall_v;
  assign FlushF    = flush_v;
  assign PC_In     = ovr_v ? ovr_pc : PCF + 32'd4;

  pc_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .CLK(CLK), .CPU_RST_N(CPU_RST_N), .PC_In(PC_In), .FlushF(FlushF),
    .StallF(StallF), .PCF(PCF), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemAck(ImemAck), .ImemRdata(ImemRdata), .InstrF(InstrF),
    .PcOutF(PcOutF), .InstrValidF(InstrValidF)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_tgt, m_instr, m_pcout, m_nxt;
  logic        m_boot, m_park, m_kill, m_valid;
  logic        hs_pend;
  logic [31:0] hs_addr;

  always @(posedge CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      m_pc = RST_PC; m_tgt = 32'h0; m_instr = NOP; m_pcout = 32'h0;
      m_boot = 1'b1; m_park = 1'b0; m_kill = 1'b0; m_valid = 1'b0;
      hs_pend = 1'b0; hs_addr = 32'h0;
    end else begin
      // Protocol record: a request seen without ack must persist unchanged.
      hs_pend = ImemReq && !ImemAck;
      hs_addr = ImemAddr;
      m_nxt = ovr_v ? ovr_pc : m_pc + 32'd4;
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_park) begin
        // The parked word is always the one at the (unchanged) fetch PC.
        if (flush_v) begin
          m_park = 1'b0; m_pc = m_nxt; m_valid = 1'b0;
        end else if (!stall_v) begin
          m_instr = mem_word(m_pc); m_pcout = m_pc; m_valid = 1'b1;
          m_pc = m_nxt; m_park = 1'b0;
        end
      end else if (m_kill) begin
        if (flush_v) m_tgt = m_nxt;
        if (ack_v) begin m_pc = m_tgt; m_kill = 1'b0; end
      end else begin
        if (flush_v) begin
          m_valid = 1'b0;
          if (ack_v) m_pc = m_nxt;
          else begin m_kill = 1'b1; m_tgt = m_nxt; end
        end else if (ack_v) begin
          if (stall_v) m_park = 1'b1;
          else begin
            m_instr = mem_word(m_pc); m_pcout = m_pc; m_valid = 1'b1; m_pc = m_nxt;
          end
        end else if (!stall_v) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (CPU_RST_N === 1'b1) begin
      chk("m_PCF",      PCF,      m_pc);
      chk("m_ImemAddr", ImemAddr, m_pc);
      chk("m_ImemReq",  {31'd0, ImemReq},     {31'd0, !m_boot && !m_park});
      chk("m_InstrF",   InstrF,   m_instr);
      chk("m_PcOutF",   PcOutF,   m_pcout);
      chk("m_valid",    {31'd0, InstrValidF}, {31'd0, m_valid});
      if (hs_pend) begin
        chk("hs_req_stable",  {31'd0, ImemReq}, 32'd1);
        chk("hs_addr_stable", ImemAddr, hs_addr);
      end
    end
  end

  // Apply one cycle of stimulus and advance past the next rising edge.
  task automatic cyc(input logic a, input logic s, input logic f,
                     input logic o, input logic [31:0] p);
    ack_v = a; stall_v = s; flush_v = f; ovr_v = o; ovr_pc = p;
    @(negedge CLK);
  endtask

  logic [23:0] ackp, stp, flp;

  initial begin
    ack_v = 1'b1; stall_v = 1'b0; flush_v = 1'b0; ovr_v = 1'b0; ovr_pc = 32'h0;
    repeat (2) @(negedge CLK);
    chk("rst_PCF",    PCF,    32'h0000_0000);
    chk("rst_req",    {31'd0, ImemReq}, 32'd0);
    chk("rst_InstrF", InstrF, 32'h0000_0013);
    chk("rst_PcOutF", PcOutF, 32'h0000_0000);
    chk("rst_valid",  {31'd0, InstrValidF}, 32'd0);
    CPU_RST_N = 1'b1;

    // Sequential fetch, zero-wait memory
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("boot_req", {31'd0, ImemReq}, 32'd1);
    chk("boot_valid", {31'd0, InstrValidF}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("seq_PCF", PCF, 32'h0000_0004);
    chk("seq_PcOutF", PcOutF, 32'h0000_0000);
    chk("seq_InstrF", InstrF, 32'h1357_0000);
    chk("seq_valid", {31'd0, InstrValidF}, 32'd1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("seq_PCF10", PCF, 32'h0000_0010);
    chk("seq_PcOutF0C", PcOutF, 32'h0000_000C);

    // Ack delayed three cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk("wait_addr", ImemAddr, 32'h0000_0010);
      chk("wait_req", {31'd0, ImemReq}, 32'd1);
    end
    chk("wait_valid", {31'd0, InstrValidF}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wait_PcOutF", PcOutF, 32'h0000_0010);
    chk("wait_InstrF", InstrF, 32'h1357_0010);
    chk("wait_PCF", PCF, 32'h0000_0014);

    // Stall on the ack edge at 0x20
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("hold_req", {31'd0, ImemReq}, 32'd0);
    chk("hold_PcOutF", PcOutF, 32'h0000_001C);
    chk("hold_PCF", PCF, 32'h0000_0020);
    chk("hold_valid", {31'd0, InstrValidF}, 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("hold2_req", {31'd0, ImemReq}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("unhold_PcOutF", PcOutF, 32'h0000_0020);
    chk("unhold_InstrF", InstrF, 32'h1357_0020);
    chk("unhold_addr", ImemAddr, 32'h0000_0024);

    // Flush while request to 0x30 is pending
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100);
    chk("drain_addr", ImemAddr, 32'h0000_0030);
    chk("drain_valid", {31'd0, InstrValidF}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("drain_addr2", ImemAddr, 32'h0000_0030);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_addr", ImemAddr, 32'h0000_0100);
    chk("redir_valid", {31'd0, InstrValidF}, 32'd0);
    chk("redir_PcOutF", PcOutF, 32'h0000_002C);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_InstrF", InstrF, 32'h1357_0100);

    // Flush coincident with ack at 0x40
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
    chk("jump_PCF", PCF, 32'h0000_0040);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0200);
    chk("fack_addr", ImemAddr, 32'h0000_0200);
    chk("fack_valid", {31'd0, InstrValidF}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("fack_PcOutF", PcOutF, 32'h0000_0200);
    chk("fack_InstrF", InstrF, 32'h1357_0200);

    // Flush and stall together in HOLD
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
    chk("hflush_PCF", PCF, 32'h0000_0300);
    chk("hflush_valid", {31'd0, InstrValidF}, 32'd0);
    chk("hflush_req", {31'd0, ImemReq}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("hflush_PcOutF", PcOutF, 32'h0000_0300);

    // Stall alone keeps valid; release without ack clears it
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_keeps_valid", {31'd0, InstrValidF}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("nostall_clears_valid", {31'd0, InstrValidF}, 32'd0);

    // Two redirects while draining: last wins
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0400);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0500);
    chk("dd_addr", ImemAddr, 32'h0000_0304);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("dd_target", ImemAddr, 32'h0000_0500);

    // Reset asserted mid-DRAIN acts asynchronously
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0600);
    #2 CPU_RST_N = 1'b0;
    #1;
    chk("arst_PCF",    PCF,    32'h0000_0000);
    chk("arst_req",    {31'd0, ImemReq}, 32'd0);
    chk("arst_InstrF", InstrF, 32'h0000_0013);
    chk("arst_PcOutF", PcOutF, 32'h0000_0000);
    chk("arst_valid",  {31'd0, InstrValidF}, 32'd0);
    ack_v = 1'b0; stall_v = 1'b0; flush_v = 1'b0; ovr_v = 1'b0;
    repeat (2) @(negedge CLK);
    CPU_RST_N = 1'b1;

    // Mixed traffic checked by the model
    ackp = 24'b1101_0110_1110_0101_1011_0111;
    stp  = 24'b0010_1000_0100_0110_0001_0100;
    flp  = 24'b0000_0100_0001_0000_1000_0010;
    for (int i = 0; i < 24; i++) begin
      cyc(ackp[i], stp[i], flp[i], flp[i], 32'h0000_0800 + 32'(i) * 32'd16);
    end
    repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end that consumes the next-PC value from the next-PC generator. It owns the fetch PC register and drives a request/acknowledge instruction-memory port. It delivers fetched instructions with their PC into the IF/ID boundary. It also handles pipeline stalls and control-flow flushes, including redirects that arrive while a memory request is still outstanding.

## Interface
- Parameters:
  - RESET_PC, default 32'h0000_0000, first fetch address after reset
  - NOP_INSTR, default 32'h0000_0013, value of InstrF while invalid/after reset
- Ports:
  - CLK  in  1  single clock, rising edge
  - CPU_RST_N  in  1  asynchronous, active-low reset
  - PC_In  in  32  next PC from next-PC generator (combinational function of PCF)
  - FlushF  in  1  redirect taken (branch/jal/jalr); PC_In holds the target
  - StallF  in  1  IF/ID cannot accept; hold outputs
  - PCF  out  32  current fetch address; feeds next-PC generator and ImemAddr
  - ImemReq  out  1  request valid
  - ImemAddr  out  32  request address (= PCF)
  - ImemAck  in  1  response handshake; transfer completes on an edge where ImemReq && ImemAck
  - ImemRdata  in  32  instruction word, valid when ImemAck
  - InstrF  out  32  registered instruction to decode
  - PcOutF  out  32  registered PC of InstrF
  - InstrValidF  out  1  InstrF/PcOutF valid

## Operation
- FSM states:
  - BOOT: after reset; ImemReq=0; next edge -> REQ.
  - REQ: ImemReq=1, ImemAddr=PCF.
  - HOLD: response parked in skid register; ImemReq=0.
  - DRAIN: killed request still outstanding; ImemReq=1, address unchanged.
- Handshake rule: once ImemReq is high, ImemReq and ImemAddr stay stable until the ack edge. Requests are never withdrawn.
- REQ transitions, FlushF has priority over StallF:
  - FlushF && ImemAck: discard data; PCF<=PC_In; InstrValidF<=0; stay REQ.
  - FlushF && !ImemAck: target<=PC_In; InstrValidF<=0; -> DRAIN.
  - ImemAck && !StallF: InstrF<=ImemRdata; PcOutF<=PCF; InstrValidF<=1; PCF<=PC_In; stay REQ.
  - ImemAck && StallF: skid<={PCF, ImemRdata}; -> HOLD. PCF and outputs are unchanged.
  - No ack: outputs hold. If !StallF, InstrValidF<=0, because decode consumed the old word.
- HOLD transitions:
  - FlushF: drop skid; PCF<=PC_In; InstrValidF<=0; -> REQ.
  - !StallF: InstrF/PcOutF<=skid; InstrValidF<=1; PCF<=PC_In; -> REQ.
  - otherwise hold.
- DRAIN transitions:
  - ImemAck: discard data; PCF<=target; -> REQ.
  - A further FlushF while in DRAIN overwrites target with PC_In; last redirect wins.
- StallF alone never clears InstrValidF.
- Widths: all PC arithmetic is outside the block. PCF is taken verbatim from PC_In with no alignment check; wrap-around at 2^32 is the generator's concern.

## Timing
- Reset values: PCF=RESET_PC, ImemReq=0, InstrF=NOP_INSTR, PcOutF=0, InstrValidF=0, state=BOOT, skid=0, target=0.
- First ImemReq is the second cycle after reset deassertion.
- Reset asserted mid-request aborts immediately. The memory side must tolerate ImemReq dropping under reset.
- Fetch latency: the word acked at edge n appears on InstrF after edge n, i.e. in cycle n+1.
- With zero-wait memory (ImemAck tied high) throughput is one instruction per cycle.
- Redirect penalty:
  - Flush coinciding with ack: the target request is issued the next cycle.
  - Flush during a wait: the target is requested the cycle after the killed ack.

## Structure
- Shared package pc_fetch_pkg:
  - fetch_state_t enum (BOOT, REQ, HOLD, DRAIN)
  - NOP_INSTR constant
  - default RESET_PC
- Sub-module fetch_skid_reg: one-entry {pc, instr} holding register with load/clear. The FSM, PCF, and output registers live in pc_fetch_unit.

## Test plan
- Reset with ack tied 1, PC_In=PCF+4: PCF sequence 0,4,8,…; InstrValidF rises the cycle after the first ack; PcOutF lags PCF by one cycle.
- Ack delayed 3 cycles at PCF=0x10, PC_In=0x14: ImemReq/ImemAddr=0x10 stable for 4 cycles; InstrF=ImemRdata, PcOutF=0x10 on the next cycle.
- StallF=1 on the ack edge at PCF=0x20: state HOLD, outputs unchanged, ImemReq=0. StallF drops after 2 cycles -> PcOutF=0x20, then request to 0x24.
- FlushF with PC_In=0x100 while a request to 0x30 is pending: ImemAddr stays 0x30 until ack, data discarded, InstrValidF=0; next request to 0x100.
- FlushF coincident with ack at 0x40, PC_In=0x200: ack data never appears on InstrF; next ImemAddr=0x200.
- FlushF and StallF both high in HOLD: skid dropped, PCF=PC_In, InstrValidF=0. CPU_RST_N low mid-DRAIN: all outputs return to reset values asynchronously.
